uart_tx_fifo: RTL and testbench

Transmit-side buffer of the UART peripheral, sitting between the processor's `UARTwr` path and the UART transmitter. It accepts bytes from the control unit one per cycle, stores up to `fifoDepth` of them in arrival order, and presents the oldest byte to the transmitter. `empty` inverted drives the transmitter's `txStart`, and the transmitter's `txDoneTick` drives `rd`. It also provides fill count and sticky error flags for `UARTstat`.

---
 rtl/uart_tx_fifo.sv | 113 +++++++++++
 tb/tb_uart_tx_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO for the UART: buffers control-unit writes and hands the
// oldest byte to the transmitter, with occupancy count and sticky error flags.
module uart_tx_fifo #(
  parameter int unsigned dataBits      = 8,
  parameter int unsigned fifoWidth     = 4,
  parameter int unsigned fifoDepth     = 16,
  parameter int unsigned fifoCntrWidth = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [dataBits-1:0]      wrData,
  input  logic                     rd,
  output logic [dataBits-1:0]      rdData,
  output logic                     empty,
  output logic                     full,
  output logic [fifoCntrWidth-1:0] count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clrErr
);

  logic [dataBits-1:0]      r_mem [fifoDepth];
  logic [fifoWidth-1:0]     r_wptr;
  logic [fifoWidth-1:0]     r_rptr;
  logic [fifoCntrWidth-1:0] r_cnt;
  logic [dataBits-1:0]      r_rd_data;
  logic                     r_overflow;
  logic                     r_underflow;

  logic                     w_empty;
  logic                     w_full;
  logic                     w_pop_ok;
  logic                     w_push_ok;
  logic [fifoWidth-1:0]     w_wptr_d;
  logic [fifoWidth-1:0]     w_rptr_d;
  logic [fifoCntrWidth-1:0] w_cnt_d;
  logic [dataBits-1:0]      w_rd_data_d;
  logic                     w_overflow_d;
  logic                     w_underflow_d;

  // Status is decoded from the occupancy counter, so full/empty never alias.
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == fifoCntrWidth'(fifoDepth));

  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  assign w_pop_ok  = rd && !w_empty;
  assign w_push_ok = wr && (!w_full || w_pop_ok);

  always_comb begin
    w_wptr_d      = r_wptr;
    w_rptr_d      = r_rptr;
    w_cnt_d       = r_cnt;
    w_rd_data_d   = r_rd_data;
    w_overflow_d  = clrErr ? 1'b0 : r_overflow;
    w_underflow_d = clrErr ? 1'b0 : r_underflow;

    if (w_push_ok) begin
      w_wptr_d = r_wptr + fifoWidth'(1);
    end
    if (w_pop_ok) begin
      w_rptr_d    = r_rptr + fifoWidth'(1);
      w_rd_data_d = r_mem[r_rptr];
    end

    unique case ({w_push_ok, w_pop_ok})
      2'b10:   w_cnt_d = r_cnt + fifoCntrWidth'(1);
      2'b01:   w_cnt_d = r_cnt - fifoCntrWidth'(1);
      default: w_cnt_d = r_cnt;
    endcase

    // A new error wins over a same-cycle clear.
    if (wr && !w_push_ok) begin
      w_overflow_d = 1'b1;
    end
    if (rd && !w_pop_ok) begin
      w_underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_rd_data   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wptr      <= w_wptr_d;
      r_rptr      <= w_rptr_d;
      r_cnt       <= w_cnt_d;
      r_rd_data   <= w_rd_data_d;
      r_overflow  <= w_overflow_d;
      r_underflow <= w_underflow_d;
    end
  end

  // Storage is deliberately not reset; stale entries sit outside the valid window.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= wrData;
    end
  end

  assign rdData    = r_rd_data;
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_cnt;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset;
  logic       wr;
  logic [7:0] wrData;
  logic       rd;
  logic [7:0] rdData;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       clrErr;

  int vectors;
  int miscompares;

  // Reference model state.
  logic [7:0] m_q [$];
  logic [7:0] m_rd;
  logic       m_ov;
  logic       m_un;

  logic [16:0] w_act;
  assign w_act = {count, empty, full, overflow, underflow, rdData};

  uart_tx_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .wrData    (wrData),
    .rd        (rd),
    .rdData    (rdData),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .clrErr    (clrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model_vec();
    int n;
    n = m_q.size();
    return {5'(n), (n == 0), (n == 16), m_ov, m_un, m_rd};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rd = 8'h00;
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic pop_ok;
    logic push_ok;
    pop_ok  = r && (m_q.size() > 0);
    push_ok = w && ((m_q.size() < 16) || pop_ok);
    if (pop_ok) m_rd = m_q.pop_front();
    if (push_ok) m_q.push_back(d);
    m_ov = (c ? 1'b0 : m_ov) | (w && !push_ok);
    m_un = (c ? 1'b0 : m_un) | (r && !pop_ok);
  endtask

  // Apply one cycle of inputs, advance past the edge, and update the model.
  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr = w; wrData = d; rd = r; clrErr = c;
    @(posedge clk);
    #1;
    model_step(w, d, r, c);
    wr = 1'b0; rd = 1'b0; clrErr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    repeat (5) drive(1'b0, 8'h00, 1'b0, 1'b0);
    vectors++;
    if (w_act !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", w_act, {5'd0, 4'b1000, 8'h00});
    end
  endtask

  task automatic test_fifo_order();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    for (int i = 0; i < 3; i++) drive(1'b1, exp_b[i], 1'b0, 1'b0);
    vectors++;
    if (count !== 5'd3) begin
      miscompares++;
      $display("FAIL order_fill_count: got %0d expected 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (rdData !== exp_b[i] || count !== 5'(2 - i) || w_act !== model_vec()) begin
        miscompares++;
        $display("FAIL order_pop%0d: got rdData=%h count=%0d expected rdData=%h count=%0d",
                 i, rdData, count, exp_b[i], 2 - i);
      end
    end
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL order_empty: got %b expected 1", empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 15) begin
        vectors++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL ovf_at16: got full=%b count=%0d ovf=%b expected 1 16 0",
                   full, count, overflow);
        end
      end
    end
    vectors++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_at17: got full=%b count=%0d ovf=%b expected 1 16 1",
               full, count, overflow);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (rdData !== 8'(i) || w_act !== model_vec()) begin
        miscompares++;
        $display("FAIL ovf_pop%0d: got %h expected %h", i, w_act, model_vec());
      end
    end
    // Clear with no new error drops the flag.
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if (overflow !== 1'b0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_clear: got ovf=%b empty=%b expected 0 1", overflow, empty);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(8'h90 + i), 1'b1, 1'b0);
      vectors++;
      if (count !== 5'd16 || overflow !== 1'b0 || underflow !== 1'b0
          || rdData !== 8'(8'h80 + i) || w_act !== model_vec()) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: got %h expected rdData=%h model %h",
                 i, w_act, 8'(8'h80 + i), model_vec());
      end
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      vectors++;
      if (rdData !== 8'(8'h94 + i)) begin
        miscompares++;
        $display("FAIL b2b_drain%0d: got %h expected %h", i, rdData, 8'(8'h94 + i));
      end
    end
  endtask

  task automatic test_empty_simul();
    logic [7:0] prev;
    prev = m_rd;
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    vectors++;
    if (underflow !== 1'b1 || count !== 5'd1 || rdData !== prev) begin
      miscompares++;
      $display("FAIL simul_empty: got unf=%b count=%0d rdData=%h expected 1 1 %h",
               underflow, count, rdData, prev);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_clr: got %b expected 0", underflow);
    end
    // Clear and a new underflow in the same cycle: set wins.
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    vectors++;
    if (rdData !== 8'h55 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_pop: got rdData=%h empty=%b expected 55 1", rdData, empty);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    vectors++;
    if (underflow !== 1'b1 || w_act !== model_vec()) begin
      miscompares++;
      $display("FAIL set_wins: got %h expected %h", w_act, model_vec());
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (w_act !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", w_act, {5'd0, 4'b1000, 8'h00});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    vectors++;
    if (rdData !== 8'h99 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_pop: got rdData=%h empty=%b expected 99 1", rdData, empty);
    end
  endtask

  task automatic test_random();
    logic       w;
    logic       r;
    logic       c;
    int         bias;
    for (int i = 0; i < 600; i++) begin
      // Slowly shifting bias drives the FIFO through both full and empty.
      bias = ((i / 100) % 2 == 0) ? 70 : 30;
      w = ($urandom_range(99) < bias);
      r = ($urandom_range(99) < (100 - bias));
      c = ($urandom_range(99) < 8);
      drive(w, 8'($urandom), r, c);
      vectors++;
      if (w_act !== model_vec()) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, w_act, model_vec());
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b1;
    wr     = 1'b0;
    wrData = 8'h00;
    rd     = 1'b0;
    clrErr = 1'b0;
    model_reset();
    test_reset();
    test_fifo_order();
    test_overflow();
    test_back_to_back();
    test_empty_simul();
    test_reset_midburst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
